// File: rtl/back_ground_animated_if.sv
// Pixel-path bus for back_ground_animated: pixel coordinates, frame strobe,
// mode select, rectangle-table write port and the registered colour outputs.
`default_nettype none

interface back_ground_animated_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [1:0]  mode;
  logic        wrEn;
  logic [2:0]  wrIdx;
  logic [2:0]  wrField;
  logic [10:0] wrData;
  logic [7:0]  BG_RGB;
  logic        boardersDrawReq;
  logic [5:0]  curOffset;

  modport master (
    output pixelX, pixelY, startOfFrame, mode, wrEn, wrIdx, wrField, wrData,
    input  BG_RGB, boardersDrawReq, curOffset
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, mode, wrEn, wrIdx, wrField, wrData,
    output BG_RGB, boardersDrawReq, curOffset
  );
endinterface

`default_nettype wire

// File: rtl/back_ground_animated.sv
// Animated VGA background painter: base fill, scrolling stripes, double-buffered
// rectangles, outer border and a blinking/breathing bracket frame. 1-clk latency.
`default_nettype none

module back_ground_animated #(
  parameter int          X_FRAME       = 639,
  parameter int          Y_FRAME       = 479,
  parameter int          NUM_RECTS     = 4,
  parameter int          BRACKET_MIN   = 10,
  parameter int          BRACKET_MAX   = 40,
  parameter int          BLINK_FRAMES  = 30,
  parameter int          STRIPE_LOG2   = 4,
  parameter logic [7:0]  BASE_COLOR    = 8'h58,
  parameter logic [7:0]  BORDER_COLOR  = 8'hFC,
  parameter logic [7:0]  BRACKET_COLOR = 8'hFF,
  parameter logic [7:0]  STRIPE_COLOR  = 8'h4A
) (
  input  logic                   clk,
  input  logic                   resetN,
  back_ground_animated_if.slave  bus
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SC_W = STRIPE_LOG2 + 1;

  typedef enum logic [0:0] {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  logic [1:0]      active_mode;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;
  logic [SC_W-1:0] scroll;
  logic [5:0]      cur_offset;
  dir_t            dir;

  logic [10:0] sh_x0 [NUM_RECTS];
  logic [10:0] sh_y0 [NUM_RECTS];
  logic [10:0] sh_x1 [NUM_RECTS];
  logic [10:0] sh_y1 [NUM_RECTS];
  logic [7:0]  sh_col [NUM_RECTS];
  logic        sh_en [NUM_RECTS];
  logic [10:0] act_x0 [NUM_RECTS];
  logic [10:0] act_y0 [NUM_RECTS];
  logic [10:0] act_x1 [NUM_RECTS];
  logic [10:0] act_y1 [NUM_RECTS];
  logic [7:0]  act_col [NUM_RECTS];
  logic        act_en [NUM_RECTS];

  logic [7:0] bg_rgb;
  logic       draw_req;

  // Animation state only advances on the frame strobe so a frame never tears.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_mode <= 2'd0;
      frame_cnt   <= '0;
      blink_on    <= 1'b1;
      scroll      <= '0;
      cur_offset  <= 6'(BRACKET_MAX);
      dir         <= DIR_DOWN;
    end else if (bus.startOfFrame) begin
      active_mode <= bus.mode;
      scroll      <= scroll + 1'b1;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (bus.mode == 2'd3) begin
        if (dir == DIR_DOWN) begin
          if (cur_offset == 6'(BRACKET_MIN)) begin
            cur_offset <= cur_offset + 1'b1;
            dir        <= DIR_UP;
          end else begin
            cur_offset <= cur_offset - 1'b1;
          end
        end else begin
          if (cur_offset == 6'(BRACKET_MAX)) begin
            cur_offset <= cur_offset - 1'b1;
            dir        <= DIR_DOWN;
          end else begin
            cur_offset <= cur_offset + 1'b1;
          end
        end
      end else begin
        cur_offset <= 6'(BRACKET_MAX);
        dir        <= DIR_DOWN;
      end
    end
  end

  // Active table takes the pre-write shadow contents on the frame strobe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x0[i] <= '0; sh_y0[i] <= '0; sh_x1[i] <= '0; sh_y1[i] <= '0;
        sh_col[i] <= '0; sh_en[i] <= 1'b0;
        act_x0[i] <= '0; act_y0[i] <= '0; act_x1[i] <= '0; act_y1[i] <= '0;
        act_col[i] <= '0; act_en[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (bus.startOfFrame) begin
          act_x0[i]  <= sh_x0[i];
          act_y0[i]  <= sh_y0[i];
          act_x1[i]  <= sh_x1[i];
          act_y1[i]  <= sh_y1[i];
          act_col[i] <= sh_col[i];
          act_en[i]  <= sh_en[i];
        end
        if (bus.wrEn && bus.wrIdx == 3'(i)) begin
          case (bus.wrField)
            3'd0: sh_x0[i]  <= bus.wrData;
            3'd1: sh_y0[i]  <= bus.wrData;
            3'd2: sh_x1[i]  <= bus.wrData;
            3'd3: sh_y1[i]  <= bus.wrData;
            3'd4: sh_col[i] <= bus.wrData[7:0];
            3'd5: sh_en[i]  <= bus.wrData[0];
            default: ;
          endcase
        end
      end
    end
  end

  logic        visible;
  logic [11:0] stripe_sum;
  logic [10:0] off_ext;
  logic        bracket_hit;
  logic        bracket_show;
  logic [7:0]  color_next;
  logic        req_next;

  assign visible      = (bus.pixelX <= 11'(X_FRAME)) && (bus.pixelY <= 11'(Y_FRAME));
  assign stripe_sum   = {1'b0, bus.pixelX} + 12'(scroll);
  assign off_ext      = {5'd0, cur_offset};
  assign bracket_hit  = (bus.pixelX == off_ext) || (bus.pixelY == off_ext) ||
                        (bus.pixelX == 11'(X_FRAME) - off_ext) ||
                        (bus.pixelY == 11'(Y_FRAME) - off_ext);
  assign bracket_show = !(active_mode == 2'd1 && !blink_on);

  always_comb begin
    color_next = BASE_COLOR;
    req_next   = 1'b0;
    if (visible) begin
      if (active_mode == 2'd2 && stripe_sum[STRIPE_LOG2])
        color_next = STRIPE_COLOR;
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (act_en[i] &&
            bus.pixelX >= act_x0[i] && bus.pixelX <= act_x1[i] &&
            bus.pixelY >= act_y0[i] && bus.pixelY <= act_y1[i])
          color_next = act_col[i];
      end
      if (bus.pixelX == 11'd0 || bus.pixelY == 11'd0 ||
          bus.pixelX == 11'(X_FRAME) || bus.pixelY == 11'(Y_FRAME))
        color_next = BORDER_COLOR;
      if (bracket_hit && bracket_show) begin
        color_next = BRACKET_COLOR;
        req_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bg_rgb   <= 8'hFF;
      draw_req <= 1'b0;
    end else begin
      bg_rgb   <= color_next;
      draw_req <= req_next;
    end
  end

  assign bus.BG_RGB          = bg_rgb;
  assign bus.boardersDrawReq = draw_req;
  assign bus.curOffset       = cur_offset;

endmodule

`default_nettype wire

// File: tb/tb_back_ground_animated.sv
// Randomised self-checking bench for back_ground_animated against a frame-level
// behavioural model, plus literal expectations from the test plan.
`default_nettype none

module tb_back_ground_animated;
  localparam int XF = 639, YF = 479, NR = 4, BMIN = 10, BMAX = 40, BF = 30, SL = 4;
  localparam int BASE = 'h58, BORDER = 'hFC, BRACKET = 'hFF, STRIPE = 'h4A;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  back_ground_animated_if bus();
  back_ground_animated dut (.clk(clk), .resetN(resetN), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: rect tables, frame count since reset, consecutive breathe frames.
  int m_sx0[8], m_sy0[8], m_sx1[8], m_sy1[8], m_scol[8], m_sen[8];
  int m_ax0[8], m_ay0[8], m_ax1[8], m_ay1[8], m_acol[8], m_aen[8];
  int m_mode, m_frames, m_bk;

  function automatic int m_offset();
    int r, p;
    r = BMAX - BMIN;
    p = m_bk % (2 * r);
    return (p <= r) ? BMAX - p : BMIN + (p - r);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sx0[i] = 0; m_sy0[i] = 0; m_sx1[i] = 0; m_sy1[i] = 0; m_scol[i] = 0; m_sen[i] = 0;
      m_ax0[i] = 0; m_ay0[i] = 0; m_ax1[i] = 0; m_ay1[i] = 0; m_acol[i] = 0; m_aen[i] = 0;
    end
    m_mode = 0; m_frames = 0; m_bk = 0;
  endfunction

  function automatic void model_pixel(input int x, input int y, output int rgb, output int req);
    int off, scroll;
    bit blink;
    rgb = BASE; req = 0;
    if (x > XF || y > YF) return;
    scroll = m_frames % (1 << (SL + 1));
    blink  = ((m_frames / BF) % 2) == 0;
    off    = m_offset();
    if (m_mode == 2 && (((x + scroll) >> SL) & 1) == 1) rgb = STRIPE;
    for (int i = 0; i < NR; i++)
      if (m_aen[i] != 0 && x >= m_ax0[i] && x <= m_ax1[i] && y >= m_ay0[i] && y <= m_ay1[i])
        rgb = m_acol[i];
    if (x == 0 || y == 0 || x == XF || y == YF) rgb = BORDER;
    if ((x == off || y == off || x == XF - off || y == YF - off) && !(m_mode == 1 && !blink)) begin
      rgb = BRACKET; req = 1;
    end
  endfunction

  // Compare process: expectation from pre-edge model state, then advance the model.
  initial begin
    int e_rgb, e_req, e_off;
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetN) begin
        model_reset();
        e_rgb = 'hFF; e_req = 0;
      end else begin
        model_pixel(int'(bus.pixelX), int'(bus.pixelY), e_rgb, e_req);
        if (bus.startOfFrame) begin
          for (int i = 0; i < 8; i++) begin
            m_ax0[i] = m_sx0[i]; m_ay0[i] = m_sy0[i]; m_ax1[i] = m_sx1[i];
            m_ay1[i] = m_sy1[i]; m_acol[i] = m_scol[i]; m_aen[i] = m_sen[i];
          end
          m_mode = int'(bus.mode);
          m_frames++;
          m_bk = (bus.mode == 2'd3) ? m_bk + 1 : 0;
        end
        if (bus.wrEn && int'(bus.wrIdx) < NR) begin
          case (int'(bus.wrField))
            0: m_sx0[bus.wrIdx]  = int'(bus.wrData);
            1: m_sy0[bus.wrIdx]  = int'(bus.wrData);
            2: m_sx1[bus.wrIdx]  = int'(bus.wrData);
            3: m_sy1[bus.wrIdx]  = int'(bus.wrData);
            4: m_scol[bus.wrIdx] = int'(bus.wrData[7:0]);
            5: m_sen[bus.wrIdx]  = int'(bus.wrData[0]);
            default: ;
          endcase
        end
      end
      e_off = m_offset();
      #1;
      chk("model_rgb", int'(bus.BG_RGB), e_rgb);
      chk("model_req", int'(bus.boardersDrawReq), e_req);
      chk("model_offset", int'(bus.curOffset), e_off);
    end
  end

  task automatic drive(input int x, input int y, input bit sof, input int md,
                       input bit we, input int idx, input int fld, input int data);
    @(negedge clk);
    bus.pixelX = 11'(x); bus.pixelY = 11'(y); bus.startOfFrame = sof;
    bus.mode = 2'(md); bus.wrEn = we; bus.wrIdx = 3'(idx);
    bus.wrField = 3'(fld); bus.wrData = 11'(data);
  endtask

  int cur_mode = 0;

  task automatic idle(input int x, input int y);
    drive(x, y, 1'b0, cur_mode, 1'b0, 0, 0, 0);
  endtask

  task automatic pix(input string name, input int x, input int y, input int rgb, input int req);
    idle(x, y);
    @(posedge clk); #2;
    chk({name, "_rgb"}, int'(bus.BG_RGB), rgb);
    chk({name, "_req"}, int'(bus.boardersDrawReq), req);
  endtask

  task automatic wr(input int idx, input int fld, input int data);
    drive(300, 300, 1'b0, cur_mode, 1'b1, idx, fld, data);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 700), $urandom_range(0, 500), 1'b1, cur_mode, 1'b0, 0, 0, 0);
      idle($urandom_range(0, 700), $urandom_range(0, 500));
    end
  endtask

  initial begin
    bus.pixelX = '0; bus.pixelY = '0; bus.startOfFrame = 1'b0; bus.mode = '0;
    bus.wrEn = 1'b0; bus.wrIdx = '0; bus.wrField = '0; bus.wrData = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_rgb", int'(bus.BG_RGB), 'hFF);
    chk("reset_offset", int'(bus.curOffset), 40);
    resetN = 1'b1;

    pix("border00", 0, 0, 'hFC, 0);
    pix("bracket40", 40, 100, 'hFF, 1);
    pix("base", 100, 100, 'h58, 0);
    pix("right_border", 639, 200, 'hFC, 0);
    pix("right_bracket", 599, 200, 'hFF, 1);
    pix("blank_x", 640, 200, 'h58, 0);
    pix("blank_y", 100, 480, 'h58, 0);

    wr(0, 0, 100); wr(0, 1, 100); wr(0, 2, 200); wr(0, 3, 150); wr(0, 4, 'h03); wr(0, 5, 1);
    wr(5, 5, 1);
    pix("shadow_only", 150, 120, 'h58, 0);
    frames(1);
    pix("rect0_in", 150, 120, 'h03, 0);
    pix("rect0_edge_out", 201, 120, 'h58, 0);
    pix("rect0_edge_in", 200, 150, 'h03, 0);

    wr(1, 0, 150); wr(1, 1, 110); wr(1, 2, 250); wr(1, 3, 130); wr(1, 4, 'hE0); wr(1, 5, 1);
    frames(1);
    pix("overlap_hi", 160, 120, 'hE0, 0);
    pix("overlap_lo", 120, 120, 'h03, 0);

    cur_mode = 1;
    frames(1);
    pix("blink_on", 40, 100, 'hFF, 1);
    frames(27);
    pix("blink_off", 40, 100, 'h58, 0);
    frames(30);
    pix("blink_on_again", 40, 100, 'hFF, 1);

    cur_mode = 3;
    frames(1);
    @(negedge clk);
    chk("breathe_first", int'(bus.curOffset), 39);
    frames(29);
    @(negedge clk);
    chk("breathe_min", int'(bus.curOffset), 10);
    frames(1);
    @(negedge clk);
    chk("breathe_turn", int'(bus.curOffset), 11);
    cur_mode = 0;
    frames(1);
    @(negedge clk);
    chk("breathe_exit", int'(bus.curOffset), 40);

    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    pix("after_reset_rect", 150, 120, 'h58, 0);
    cur_mode = 2;
    frames(32);
    pix("stripe_16", 16, 100, 'h4A, 0);
    pix("stripe_15", 15, 100, 'h58, 0);
    frames(1);
    pix("stripe_scrolled", 15, 100, 'h4A, 0);
    pix("stripe_blank", 700, 100, 'h58, 0);

    for (int n = 0; n < 3000; n++) begin
      int x, y, sel, off;
      off = m_offset();
      sel = $urandom_range(0, 5);
      x = $urandom_range(0, 760);
      y = $urandom_range(0, 560);
      if (sel == 0) x = (($urandom_range(0, 1) == 0) ? off : XF - off);
      if (sel == 1) y = (($urandom_range(0, 1) == 0) ? off : YF - off);
      if (sel == 2) x = m_ax0[$urandom_range(0, NR - 1)] + $urandom_range(0, 2) - 1;
      if (sel == 3) y = (($urandom_range(0, 1) == 0) ? 0 : YF);
      if (x < 0) x = 0;
      drive(x, y, $urandom_range(0, 19) == 0, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 700) : $urandom_range(0, 2047));
      if (n == 1500) begin
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
      end
    end
    idle(0, 0);
    @(posedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
